// File: rtl/hsv_blob_accum_if.sv
// Pixel and result bundle between the rgb2hsv converter side and the blob accumulator.
// The slave modport is the accumulator; the master modport drives pixels and reads results.
interface hsv_blob_accum_if;
  logic        frame_start;
  logic        done;
  logic [8:0]  hue;
  logic        hue_invalid;
  logic [4:0]  saturation;
  logic [4:0]  value;
  logic [8:0]  hue_lo;
  logic [8:0]  hue_hi;
  logic [4:0]  sat_min;
  logic [4:0]  val_min;

  logic        result_valid;
  logic        frame_short;
  logic        blob_found;
  logic [16:0] count;
  logic [24:0] sum_x;
  logic [24:0] sum_y;
  logic [8:0]  x_min;
  logic [8:0]  x_max;
  logic [8:0]  y_min;
  logic [8:0]  y_max;

  modport slave (
    input  frame_start, done, hue, hue_invalid, saturation, value,
           hue_lo, hue_hi, sat_min, val_min,
    output result_valid, frame_short, blob_found, count, sum_x, sum_y,
           x_min, x_max, y_min, y_max
  );

  modport master (
    output frame_start, done, hue, hue_invalid, saturation, value,
           hue_lo, hue_hi, sat_min, val_min,
    input  result_valid, frame_short, blob_found, count, sum_x, sum_y,
           x_min, x_max, y_min, y_max
  );
endinterface

// File: rtl/hsv_blob_accum.sv
// Per-frame colour-window blob statistics: match count, coordinate sums and bounding box,
// published as a one-cycle result pulse at frame end (or early on a new frame_start).
module hsv_blob_accum #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic               clk,
  input  logic               res,
  hsv_blob_accum_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_PUBLISH
  } state_t;

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  state_t      r_state;
  logic        r_doneD;
  logic        r_short;
  logic        r_restart;
  logic [8:0]  r_x;
  logic [8:0]  r_y;
  logic [16:0] r_accCount;
  logic [24:0] r_accSumX;
  logic [24:0] r_accSumY;
  logic [8:0]  r_accXMin;
  logic [8:0]  r_accXMax;
  logic [8:0]  r_accYMin;
  logic [8:0]  r_accYMax;

  logic        r_resultValid;
  logic        r_frameShort;
  logic        r_blobFound;
  logic [16:0] r_count;
  logic [24:0] r_sumX;
  logic [24:0] r_sumY;
  logic [8:0]  r_xMin;
  logic [8:0]  r_xMax;
  logic [8:0]  r_yMin;
  logic [8:0]  r_yMax;

  logic        w_pix;
  logic        w_hueOk;
  logic        w_match;
  logic        w_lastPix;
  logic        w_accEmpty;

  assign w_pix = bus.done & ~r_doneD;

  // A window with lo > hi wraps through 0, which is how red hues are selected.
  assign w_hueOk = (bus.hue_lo <= bus.hue_hi)
                 ? ((bus.hue >= bus.hue_lo) && (bus.hue <= bus.hue_hi))
                 : ((bus.hue >= bus.hue_lo) || (bus.hue <= bus.hue_hi));

  assign w_match    = ~bus.hue_invalid && (bus.saturation >= bus.sat_min) &&
                      (bus.value >= bus.val_min) && w_hueOk;
  assign w_lastPix  = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_accEmpty = (r_accCount == 17'd0);

  always_ff @(posedge clk) begin
    if (res) begin
      r_state       <= S_IDLE;
      r_doneD       <= 1'b1;
      r_short       <= 1'b0;
      r_restart     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_accCount    <= '0;
      r_accSumX     <= '0;
      r_accSumY     <= '0;
      r_accXMin     <= 9'd511;
      r_accXMax     <= '0;
      r_accYMin     <= 9'd511;
      r_accYMax     <= '0;
      r_resultValid <= 1'b0;
      r_frameShort  <= 1'b0;
      r_blobFound   <= 1'b0;
      r_count       <= '0;
      r_sumX        <= '0;
      r_sumY        <= '0;
      r_xMin        <= '0;
      r_xMax        <= '0;
      r_yMin        <= '0;
      r_yMax        <= '0;
    end else begin
      r_doneD       <= bus.done;
      r_resultValid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_state <= S_ACCUM;
          end
        end

        // A frame_start mid-frame wins over a simultaneous pixel, which is discarded.
        S_ACCUM: begin
          if (bus.frame_start) begin
            r_state   <= S_PUBLISH;
            r_short   <= 1'b1;
            r_restart <= 1'b1;
          end else if (w_pix) begin
            if (w_match) begin
              r_accCount <= r_accCount + 17'd1;
              r_accSumX  <= r_accSumX + 25'(r_x);
              r_accSumY  <= r_accSumY + 25'(r_y);
              if (r_x < r_accXMin) r_accXMin <= r_x;
              if (r_x > r_accXMax) r_accXMax <= r_x;
              if (r_y < r_accYMin) r_accYMin <= r_y;
              if (r_y > r_accYMax) r_accYMax <= r_y;
            end
            if (r_x == X_LAST) begin
              r_x <= '0;
              r_y <= r_y + 9'd1;
            end else begin
              r_x <= r_x + 9'd1;
            end
            if (w_lastPix) begin
              r_state   <= S_PUBLISH;
              r_short   <= 1'b0;
              r_restart <= 1'b0;
            end
          end
        end

        // The sentinel min/max values never escape: an empty frame reports a 0/0/0/0 box.
        S_PUBLISH: begin
          r_resultValid <= 1'b1;
          r_frameShort  <= r_short;
          r_blobFound   <= ~w_accEmpty;
          r_count       <= r_accCount;
          r_sumX        <= r_accSumX;
          r_sumY        <= r_accSumY;
          r_xMin        <= w_accEmpty ? 9'd0 : r_accXMin;
          r_xMax        <= w_accEmpty ? 9'd0 : r_accXMax;
          r_yMin        <= w_accEmpty ? 9'd0 : r_accYMin;
          r_yMax        <= w_accEmpty ? 9'd0 : r_accYMax;
          r_accCount    <= '0;
          r_accSumX     <= '0;
          r_accSumY     <= '0;
          r_accXMin     <= 9'd511;
          r_accXMax     <= '0;
          r_accYMin     <= 9'd511;
          r_accYMax     <= '0;
          r_x           <= '0;
          r_y           <= '0;
          r_short       <= 1'b0;
          r_restart     <= 1'b0;
          r_state       <= (r_restart || bus.frame_start) ? S_ACCUM : S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result_valid = r_resultValid;
  assign bus.frame_short  = r_frameShort;
  assign bus.blob_found   = r_blobFound;
  assign bus.count        = r_count;
  assign bus.sum_x        = r_sumX;
  assign bus.sum_y        = r_sumY;
  assign bus.x_min        = r_xMin;
  assign bus.x_max        = r_xMax;
  assign bus.y_min        = r_yMin;
  assign bus.y_max        = r_yMax;

endmodule
